// File: rtl/hamming_7_4_tx_if.sv
// hamming_7_4_tx_if: word handshake, injection control and serial frame outputs of the Hamming(7,4) transmitter
interface hamming_7_4_tx_if #(
    parameter int COUNT_W = 8
);
    logic [3:0]         data_in;
    logic               in_valid;
    logic               in_ready;
    logic               inj_en;
    logic [2:0]         inj_pos;
    logic [7:1]         cw_out;
    logic               tx_bit;
    logic               tx_valid;
    logic               tx_first;
    logic               tx_last;
    logic               busy;
    logic [COUNT_W-1:0] frame_count;
    modport master (
        output data_in, in_valid, inj_en, inj_pos,
        input  in_ready, cw_out, tx_bit, tx_valid, tx_first, tx_last, busy, frame_count
    );
    modport slave (
        input  data_in, in_valid, inj_en, inj_pos,
        output in_ready, cw_out, tx_bit, tx_valid, tx_first, tx_last, busy, frame_count
    );
endinterface

// File: rtl/hamming_7_4_tx.sv
// hamming_7_4_tx: encodes 4-bit words into Hamming(7,4) codewords and serializes them with frame markers
module hamming_7_4_tx #(
    parameter bit LSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0,
    parameter int COUNT_W    = 8
) (
    input logic             clk,
    input logic             rst,
    hamming_7_4_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [3:0]         gap_q, gap_d;
    logic [6:0]         cw_q, cw_d, enc, flip;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               last_bit, ready, xfer, valid;
    logic [3:0]         d;
    // cw_q[i] holds codeword position i+1
    assign d        = bus.data_in;
    assign enc      = {d[0], d[1], d[2], d[2] ^ d[1] ^ d[0], d[3], d[3] ^ d[1] ^ d[0], d[3] ^ d[2] ^ d[0]};
    assign flip     = (bus.inj_en && bus.inj_pos != 3'd0) ? 7'd1 << (bus.inj_pos - 3'd1) : 7'd0;
    assign valid    = state_q == SEND;
    assign last_bit = valid && idx_q == 3'd6;
    assign ready    = state_q == IDLE || (last_bit && GAP_CYCLES == 0);
    assign xfer     = bus.in_valid && ready;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q + 3'd1;
        gap_d   = gap_q;
        cw_d    = cw_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            state_d = SEND;
            idx_d   = 3'd0;
            cw_d    = enc ^ flip;
            cnt_d   = cnt_q + 1'b1;
        end else if (last_bit) begin
            state_d = GAP_CYCLES == 0 ? IDLE : GAP;
            gap_d   = 4'(GAP_CYCLES - 1);
        end else if (state_q == GAP) begin
            state_d = gap_q == 4'd0 ? IDLE : GAP;
            gap_d   = gap_q - 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            cw_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            cw_q    <= cw_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.in_ready    = ready;
    assign bus.tx_valid    = valid;
    assign bus.tx_bit      = valid && (LSB_FIRST ? cw_q[idx_q] : cw_q[3'd6 - idx_q]);
    assign bus.tx_first    = valid && idx_q == 3'd0;
    assign bus.tx_last     = last_bit;
    assign bus.busy        = state_q != IDLE;
    assign bus.cw_out      = cw_q;
    assign bus.frame_count = cnt_q;
endmodule

// File: tb/tb_hamming_7_4_tx.sv
// tb_hamming_7_4_tx: directed vectors against a frame-stream model for an LSB-first/no-gap and an MSB-first/gap-3 instance
module tb_hamming_7_4_tx;
    localparam int G0 = 0, G1 = 3;
    typedef struct packed {logic b, l, f, v; logic [3:0] d; logic e;} ent_t;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [3:0]  din[2];
    logic        vld[2], ien[2];
    logic [2:0]  ipos[2];
    logic [20:0] obs[2];
    hamming_7_4_tx_if #(.COUNT_W(8)) if0 ();
    hamming_7_4_tx_if #(.COUNT_W(8)) if1 ();
    hamming_7_4_tx #(.LSB_FIRST(1'b1), .GAP_CYCLES(G0), .COUNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    hamming_7_4_tx #(.LSB_FIRST(1'b0), .GAP_CYCLES(G1), .COUNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    assign if0.data_in  = din[0];
    assign if0.in_valid = vld[0];
    assign if0.inj_en   = ien[0];
    assign if0.inj_pos  = ipos[0];
    assign if1.data_in  = din[1];
    assign if1.in_valid = vld[1];
    assign if1.inj_en   = ien[1];
    assign if1.inj_pos  = ipos[1];
    assign obs[0] = {if0.frame_count, if0.cw_out, if0.busy, if0.in_ready, if0.tx_last, if0.tx_first, if0.tx_valid, if0.tx_bit};
    assign obs[1] = {if1.frame_count, if1.cw_out, if1.busy, if1.in_ready, if1.tx_last, if1.tx_first, if1.tx_valid, if1.tx_bit};
    int tests = 0, errors = 0;
    bit started = 1'b0;
    ent_t st[2][24];
    int len[2], ndec[2], nb[2];
    logic [7:1] mcw[2], rx[2];
    logic [7:0] mcnt[2];
    bit mrdy[2];
    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask
    function automatic int gap_of(int k);
        return k == 0 ? G0 : G1;
    endfunction
    function automatic bit lsb_of(int k);
        return k == 0;
    endfunction
    function automatic bit mready(int k);
        return len[k] == 0 || (gap_of(k) == 0 && len[k] == 1);
    endfunction
    // Parity bit q covers every data position whose index has bit q set
    function automatic logic [7:1] enc(logic [3:0] d, logic e, logic [2:0] p);
        logic [7:1] c;
        logic x;
        c = '0;
        c[3] = d[3]; c[5] = d[2]; c[6] = d[1]; c[7] = d[0];
        for (int q = 1; q < 8; q = q * 2) begin
            x = 1'b0;
            for (int j = 3; j <= 7; j++) if (j != 4 && (j & q) != 0) x ^= c[j];
            c[q] = x;
        end
        if (e && p != 3'd0) c[int'(p)] ^= 1'b1;
        return c;
    endfunction
    function automatic logic [4:0] dec(logic [7:1] c);
        logic [2:0] s;
        s[0] = c[1] ^ c[3] ^ c[5] ^ c[7];
        s[1] = c[2] ^ c[3] ^ c[6] ^ c[7];
        s[2] = c[4] ^ c[5] ^ c[6] ^ c[7];
        if (s != 3'd0) c[int'(s)] ^= 1'b1;
        return {s != 3'd0, c[3], c[5], c[6], c[7]};
    endfunction
    // Model: each accepted word appends its 7 bit slots plus gap slots to an expected stream
    always @(posedge clk) begin
        ent_t en;
        int p;
        for (int k = 0; k < 2; k++) mrdy[k] = mready(k);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                len[k] = 0;
                mcw[k] = '0;
                mcnt[k] = '0;
            end else begin
                if (len[k] > 0) begin
                    for (int i = 0; i < 23; i++) st[k][i] = st[k][i+1];
                    len[k]--;
                end
                if (vld[k] && mrdy[k]) begin
                    mcw[k] = enc(din[k], ien[k], ipos[k]);
                    mcnt[k]++;
                    for (int i = 0; i < 7; i++) begin
                        p = lsb_of(k) ? i + 1 : 7 - i;
                        en.b = mcw[k][p]; en.l = i == 6; en.f = i == 0; en.v = 1'b1;
                        en.d = din[k]; en.e = ien[k] && ipos[k] != 3'd0;
                        st[k][len[k]] = en;
                        len[k]++;
                    end
                    for (int i = 0; i < gap_of(k); i++) begin
                        st[k][len[k]] = '0;
                        len[k]++;
                    end
                end
            end
        end
        if (rst) started = 1'b1;
    end
    always @(negedge clk) begin
        ent_t e;
        int p;
        if (started) for (int k = 0; k < 2; k++) begin
            e = len[k] > 0 ? st[k][0] : '0;
            chk("serial", k, obs[k][5:0], {len[k] > 0, mready(k), e.l, e.f, e.v, e.b});
            chk("cw_out", k, obs[k][12:6], mcw[k]);
            chk("frame_count", k, obs[k][20:13], mcnt[k]);
            if (obs[k][1]) begin
                if (obs[k][2]) nb[k] = 0;
                p = lsb_of(k) ? nb[k] + 1 : 7 - nb[k];
                if (p >= 1 && p <= 7) rx[k][p] = obs[k][0];
                nb[k]++;
                if (obs[k][3]) begin
                    chk("decode", k, dec(rx[k]), {e.e, e.d});
                    ndec[k]++;
                end
            end
        end
    end
    task automatic send(int k, logic [3:0] d, logic e, logic [2:0] p);
        int n = 0;
        din[k] = d; ien[k] = e; ipos[k] = p; vld[k] = 1'b1;
        while (!obs[k][4] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", k, n < 200, 1);
        @(negedge clk);
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
    initial begin
        logic [6:0] s, f, l;
        logic [15:0] vs;
        int last, nf, base;
        for (int k = 0; k < 2; k++) begin
            din[k] = '0; vld[k] = 0; ien[k] = 0; ipos[k] = '0; len[k] = 0; ndec[k] = 0; nb[k] = 0;
        end
        chk("model_enc_1011", 0, enc(4'b1011, 0, 3'd0), 7'b1100110);
        chk("model_enc_inj5", 0, enc(4'b1011, 1, 3'd5), 7'b1110110);
        chk("model_enc_1111", 0, enc(4'b1111, 0, 3'd0), 7'b1111111);
        chk("model_dec", 0, dec(7'b1110110), 5'b11011);
        repeat (2) @(negedge clk);
        chk("rst_cw", 0, if0.cw_out, 0);
        chk("rst_count", 0, if0.frame_count, 0);
        chk("rst_valid", 0, if0.tx_valid, 0);
        chk("rst_ready", 0, if0.in_ready, 1);
        rst = 1'b0;
        send(0, 4'b1011, 0, 3'd0);
        vld[0] = 0;
        for (int i = 0; i < 7; i++) begin
            s = {s[5:0], if0.tx_bit}; f = {f[5:0], if0.tx_first}; l = {l[5:0], if0.tx_last};
            @(negedge clk);
        end
        chk("bits_1011", 0, s, 7'b0110011);
        chk("first_flag", 0, f, 7'b1000000);
        chk("last_flag", 0, l, 7'b0000001);
        chk("cw_1011", 0, if0.cw_out, 7'b1100110);
        chk("count_1", 0, if0.frame_count, 1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        send(0, 4'b0000, 0, 3'd0);
        din[0] = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) chk("b2b_cw0", 0, if0.cw_out, 7'b0000000);
            if (i == 7) begin
                chk("b2b_cw1", 0, if0.cw_out, 7'b1111111);
                vld[0] = 0;
            end
            vs[15-i] = if0.tx_valid;
            @(negedge clk);
        end
        chk("b2b_valid_run", 0, vs, 16'b1111_1111_1111_1100);
        chk("b2b_count", 0, if0.frame_count, 2);
        send(0, 4'b1011, 1, 3'd5); vld[0] = 0;
        chk("inj_pos5", 0, if0.cw_out, 7'b1110110);
        repeat (7) @(negedge clk);
        send(0, 4'b1011, 1, 3'd0); vld[0] = 0;
        chk("inj_pos0", 0, if0.cw_out, 7'b1100110);
        repeat (7) @(negedge clk);
        send(0, 4'b1011, 0, 3'd5); vld[0] = 0;
        chk("inj_disabled", 0, if0.cw_out, 7'b1100110);
        repeat (7) @(negedge clk);
        last = -1; nf = 0;
        din[1] = 4'b0110; ien[1] = 0; vld[1] = 1;
        for (int c = 0; c < 40; c++) begin
            if (if1.tx_first) begin
                if (last >= 0) chk("gap_period", 1, c - last, 11);
                last = c;
                nf++;
            end
            if (if1.busy && !if1.tx_valid) chk("gap_not_ready", 1, if1.in_ready, 0);
            din[1] = 4'(c);
            @(negedge clk);
        end
        chk("gap_frames", 1, nf >= 3, 1);
        vld[1] = 0;
        repeat (12) @(negedge clk);
        send(0, 4'b1011, 0, 3'd0);
        repeat (3) @(negedge clk);
        chk("mid_valid", 0, if0.tx_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 0, if0.tx_valid, 0);
        chk("abort_bit", 0, if0.tx_bit, 0);
        chk("abort_busy", 0, if0.busy, 0);
        chk("abort_cw", 0, if0.cw_out, 0);
        chk("abort_count", 0, if0.frame_count, 0);
        @(negedge clk);
        chk("rst_drops_word", 0, if0.frame_count, 0);
        rst = 1'b0; vld[0] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_resume", 0, if0.tx_valid, 0);
        end
        send(0, 4'b1100, 0, 3'd0); vld[0] = 0;
        chk("fresh_first", 0, if0.tx_first, 1);
        chk("fresh_count", 0, if0.frame_count, 1);
        repeat (7) @(negedge clk);
        base = ndec[0];
        for (int d = 0; d < 16; d++)
            for (int p = 0; p < 8; p++) send(0, 4'(d), 1, 3'(p));
        vld[0] = 0;
        for (int d = 0; d < 16; d++) send(1, 4'(d), 1, 3'(d));
        vld[1] = 0;
        repeat (14) @(negedge clk);
        chk("decode_frames", 0, ndec[0] - base, 128);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/hamming_7_4_tx.md
Name: hamming_7_4_tx

Overview:
- Transmit-side counterpart of the team's Hamming(7,4) decoder.
- Accepts a 4-bit data word over a valid/ready handshake, encodes it into a 7-bit Hamming codeword, and serializes it onto a one-bit line with frame markers.
- Optional single-bit error injection lets the lab bench exercise the decoder's correction path end to end.

Parameters:
- LSB_FIRST, 1, 1 = transmit cw[1] first through cw[7]; 0 = cw[7] first through cw[1].
- GAP_CYCLES, 0, idle cycles inserted after each frame before the next can start (0..15).
- COUNT_W, 8, width of the accepted-frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- data_in  in  4  data word; bit mapping {d3,d2,d1,d0} = {cw[3],cw[5],cw[6],cw[7]}.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block can accept a word this cycle.
- inj_en  in  1  enable single-bit error injection; sampled with the accepted word.
- inj_pos  in  3  codeword position to flip (1..7); 0 = no flip even if inj_en=1.
- cw_out  out  7  [7:1] registered codeword of the current or last frame, after injection.
- tx_bit  out  1  serial data bit.
- tx_valid  out  1  tx_bit carries a codeword bit.
- tx_first  out  1  high with the first bit of a frame.
- tx_last  out  1  high with the seventh bit of a frame.
- busy  out  1  state is not IDLE.
- frame_count  out  COUNT_W  number of accepted words, wraps modulo 2^COUNT_W.

Behaviour:
- Encoding:
  - cw[3]=d3, cw[5]=d2, cw[6]=d1, cw[7]=d0.
  - cw[1]=cw3^cw5^cw7; cw[2]=cw3^cw6^cw7; cw[4]=cw5^cw6^cw7.
  - Injection XORs a one-hot at inj_pos into the codeword before it is loaded.
- Handshake:
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - data_in, inj_en and inj_pos are captured only at that edge.
  - Inputs are ignored when in_ready=0.
- States: IDLE, SEND, GAP.
  - IDLE: in_ready=1, tx_valid=0. On transfer: load cw_out and the shift register, bit index=0, frame_count+1, go to SEND.
  - SEND: tx_valid=1 for 7 consecutive cycles. Bit order follows LSB_FIRST. tx_first is high on index 0; tx_last is high on index 6.
  - On the index-6 cycle:
    - If GAP_CYCLES=0: in_ready=1. A transfer in that cycle reloads and stays in SEND, giving back-to-back frames with no idle cycle (7 cycles/frame). With no transfer, go to IDLE.
    - If GAP_CYCLES>0: in_ready=0; go to GAP.
  - GAP: tx_valid=0, in_ready=0 for exactly GAP_CYCLES cycles, then go to IDLE.
- Latency: for a transfer at edge k, the first bit is valid in the cycle after edge k, and cw_out updates at edge k.
- tx_bit is driven 0 whenever tx_valid=0.
- cw_out holds the last frame's value until the next transfer.
- frame_count wraps from all-ones to 0 without any flag.
- Reset:
  - Values: state=IDLE, in_ready=1 (combinational from state), tx_valid=0, tx_bit=0, tx_first=0, tx_last=0, busy=0, cw_out=0, frame_count=0.
  - Reset asserted mid-frame aborts the frame. tx_valid is 0 in the cycle after the reset edge, and no partial frame resumes.
  - Reset wins over a simultaneous transfer; that word is dropped and not counted.
- inj_pos values 1..7 flip exactly one bit. Value 0 flips nothing.

Test Plan:
- Reset, send data_in=4'b1011 with LSB_FIRST=1 -> cw_out=7'b1100110; serial bits 0,1,1,0,0,1,1; tx_first on bit 1, tx_last on bit 7; frame_count=1.
- Send 4'b0000 and 4'b1111 back-to-back (GAP_CYCLES=0, in_valid held) -> cw_out 7'b0000000 then 7'b1111111; 14 consecutive tx_valid cycles with no idle cycle; frame_count=2.
- Send 4'b1011 with inj_en=1, inj_pos=5 -> cw_out=7'b1110110. Repeat with inj_pos=0 -> cw_out=7'b1100110.
- GAP_CYCLES=3, in_valid held high -> each 7-bit frame is followed by 3 cycles of tx_valid=0 and in_ready=0, then a 1-cycle IDLE accept; the frame period is 11 cycles.
- Assert rst on the 4th bit of a frame while in_valid=1 -> tx_valid=0 the next cycle; all outputs at reset values; frame_count=0; the new frame starts only after a fresh transfer.
- Exhaustive loop: all 16 data words × inj_pos 0..7 looped through the team's decoder -> decoded data always equals data_in; error=1 exactly when inj_pos≠0.
